hack_boot_loader: RTL

- Sequences the Hack CPU at power-up and on demand.
- Holds the CPU in reset while it receives a program image over a byte-stream handshake. Writes the image word-by-word into instruction ROM, then releases CPU reset after a fixed hold interval.
- Sits between the host link (UART/SPI byte receiver) and the hack_no_ram core plus its instruction ROM.

---
 rtl/hack_boot_loader_if.sv | 31 +++
 rtl/hack_boot_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader_if.sv
// Host byte-stream and ROM/CPU control bundle for the Hack boot loader.
// Latency: none (wiring only).
// Backpressure: rx_ready from the loader qualifies rx_valid from the host.
`timescale 1ns/1ps
interface hack_boot_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  reload;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic                  rom_we;
  logic                  cpu_reset;
  logic                  busy;
  logic                  err;
  logic [15:0]           words_loaded;

  // Host side: supplies bytes and reload, observes loader status.
  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, rom_addr, rom_data, rom_we, cpu_reset, busy, err, words_loaded
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, rom_addr, rom_data, rom_we, cpu_reset, busy, err, words_loaded
  );
endinterface

// File: rtl/hack_boot_loader.sv
// Loads a big-endian program image into instruction ROM, then releases Hack CPU reset.
// Latency: rom_we one cycle after the LO byte edge; cpu_reset drops RESET_HOLD cycles after the last write.
// Backpressure: rx_ready high only in the receive states and while reload is low.
// Optional trailing checksum check enabled by defining HACK_BOOT_CHECKSUM_EN.
`timescale 1ns/1ps
module hack_boot_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int RESET_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  hack_boot_loader_if.slave  bus
);

  typedef enum logic [3:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
`ifdef HACK_BOOT_CHECKSUM_EN
    CSUM_HI,
    CSUM_LO,
    ERROR,
`endif
    HOLD,
    RUN
  } state_t;

  state_t                state;
  logic [15:0]           cntReg;
  logic [7:0]            hiByte;
  logic [15:0]           wordCnt;
  logic [7:0]            holdCnt;
  logic [ADDR_WIDTH-1:0] romAddr;
  logic [15:0]           romData;
  logic                  romWe;
  logic                  cpuReset;
  logic [15:0]           wordsLoaded;
  logic                  inRxState;
  logic                  xfer;
`ifdef HACK_BOOT_CHECKSUM_EN
  logic [15:0]           csum;
  logic                  errReg;
`endif

  // Bytes are accepted only while a receive state is active and no reload is requested.
  always_comb begin
    inRxState = 1'b0;
    case (state)
      CNT_HI, CNT_LO, DATA_HI, DATA_LO: inRxState = 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
      CSUM_HI, CSUM_LO:                 inRxState = 1'b1;
`endif
      default:                          inRxState = 1'b0;
    endcase
  end

  assign bus.rx_ready = inRxState && !bus.reload;
  assign xfer         = bus.rx_valid && bus.rx_ready;

  // Load sequencer: image parsing, ROM strobes, hold countdown and CPU release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CNT_HI;
      cntReg      <= '0;
      hiByte      <= '0;
      wordCnt     <= '0;
      holdCnt     <= '0;
      romAddr     <= '0;
      romData     <= '0;
      romWe       <= 1'b0;
      cpuReset    <= 1'b1;
      wordsLoaded <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
      csum        <= '0;
      errReg      <= 1'b0;
`endif
    end else begin
      romWe <= 1'b0;
      // The countdown is preloaded in every other state so HOLD always starts at RESET_HOLD.
      if (state != HOLD) holdCnt <= 8'(RESET_HOLD);
      if (bus.reload) begin
        state       <= CNT_HI;
        cpuReset    <= 1'b1;
        wordsLoaded <= '0;
        wordCnt     <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
        csum        <= '0;
        errReg      <= 1'b0;
`endif
      end else begin
        case (state)
          CNT_HI: if (xfer) begin
            cntReg[15:8] <= bus.rx_data;
            state        <= CNT_LO;
          end
          CNT_LO: if (xfer) begin
            cntReg[7:0] <= bus.rx_data;
            if ({cntReg[15:8], bus.rx_data} != 16'd0) state <= DATA_HI;
`ifdef HACK_BOOT_CHECKSUM_EN
            else state <= CSUM_HI;
`else
            else state <= HOLD;
`endif
          end
          DATA_HI: if (xfer) begin
            hiByte <= bus.rx_data;
            state  <= DATA_LO;
          end
          DATA_LO: if (xfer) begin
            romData     <= {hiByte, bus.rx_data};
            romAddr     <= ADDR_WIDTH'(wordCnt);
            romWe       <= 1'b1;
            wordsLoaded <= wordsLoaded + 16'd1;
            wordCnt     <= wordCnt + 16'd1;
`ifdef HACK_BOOT_CHECKSUM_EN
            csum        <= csum + {hiByte, bus.rx_data};
`endif
            if (wordCnt + 16'd1 != cntReg) state <= DATA_HI;
`ifdef HACK_BOOT_CHECKSUM_EN
            else state <= CSUM_HI;
`else
            else state <= HOLD;
`endif
          end
`ifdef HACK_BOOT_CHECKSUM_EN
          CSUM_HI: if (xfer) begin
            hiByte <= bus.rx_data;
            state  <= CSUM_LO;
          end
          CSUM_LO: if (xfer) begin
            if ({hiByte, bus.rx_data} == csum) begin
              state <= HOLD;
            end else begin
              state    <= ERROR;
              errReg   <= 1'b1;
              cpuReset <= 1'b1;
            end
          end
          ERROR: state <= ERROR;
`endif
          HOLD: begin
            if (holdCnt == 8'd0) begin
              state    <= RUN;
              cpuReset <= 1'b0;
            end else begin
              holdCnt <= holdCnt - 8'd1;
            end
          end
          RUN:     state <= RUN;
          default: state <= CNT_HI;
        endcase
      end
    end
  end

  assign bus.rom_addr     = romAddr;
  assign bus.rom_data     = romData;
  assign bus.rom_we       = romWe;
  assign bus.cpu_reset    = cpuReset;
  assign bus.busy         = (state != RUN);
  assign bus.words_loaded = wordsLoaded;
`ifdef HACK_BOOT_CHECKSUM_EN
  assign bus.err          = errReg;
`else
  assign bus.err          = 1'b0;
`endif

endmodule
